cmd_strobe_tx: RTL and testbench

Host-side transmitter for the 3-bit strobed command interface (C[2:0] qualified by a CLK strobe) consumed by the power-stage controller top. It accepts commands over a valid/ready handshake and serialises each one into timed strobe frames. It also expands multi-frame macros (start, discharge) into their fixed frame sequences. It sits in the supervisory/bench-driver FPGA and drives the controller's I_C0..I_C2 and I_CLK pins.

---
 rtl/at24_cmd_pkg.sv | 69 ++++++
 rtl/cmd_phase_timer.sv | 27 ++
 rtl/cmd_strobe_tx.sv | 140 ++++++++++++++
 tb/tb_cmd_strobe_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/at24_cmd_pkg.sv
// Shared definitions for the strobed 3-bit command link: command codes,
// command kinds, transmitter FSM states and the macro frame tables.
package at24_cmd_pkg;

    localparam logic [2:0] CMD_PAUSE         = 3'd0;
    localparam logic [2:0] CMD_PLUS          = 3'd1;
    localparam logic [2:0] CMD_MINUS         = 3'd2;
    localparam logic [2:0] CMD_BALLAST_P     = 3'd3;
    localparam logic [2:0] CMD_BALLAST_N     = 3'd4;
    localparam logic [2:0] CMD_START         = 3'd5;
    localparam logic [2:0] CMD_SHUTDOWN      = 3'd6;
    localparam logic [2:0] CMD_DISCHARGE_PRE = 3'd7;

    localparam int MAX_FRAMES = 5;

    typedef enum logic [1:0] {
        KIND_SINGLE     = 2'd0,
        KIND_START      = 2'd1,
        KIND_DISCHARGE  = 2'd2,
        KIND_SINGLE_ALT = 2'd3
    } cmd_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Index of the last frame in the sequence for a given command kind.
    function automatic logic [2:0] frame_last(input cmd_kind_t kind);
        case (kind)
            KIND_START:     return 3'd1;
            KIND_DISCHARGE: return 3'(MAX_FRAMES - 1);
            default:        return 3'd0;
        endcase
    endfunction

    // Code carried by frame 'step' of a command.
    //   single    : {code}
    //   start     : {5,0}
    //   discharge : {7,0,7,0,code}
    function automatic logic [2:0] frame_code(input cmd_kind_t kind,
                                              input logic [2:0] code,
                                              input logic [2:0] step);
        logic [2:0] r;
        r = code;
        case (kind)
            KIND_START:     r = (step == 3'd0) ? CMD_START : CMD_PAUSE;
            KIND_DISCHARGE: begin
                case (step)
                    3'd0, 3'd2: r = CMD_DISCHARGE_PRE;
                    3'd1, 3'd3: r = CMD_PAUSE;
                    default:    r = code;
                endcase
            end
            default:        r = code;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmd_phase_timer.sv
// Loadable down-counter used to time each strobe phase. Stops at zero.
module cmd_phase_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cmd_strobe_tx.sv
// Host-side transmitter for the strobed 3-bit command link. Accepts one
// command at a time and plays it out as SETUP/HIGH/LOW strobe frames.
//
// Handshake: a command is taken on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and kind/code are
// captured at that edge so later input changes have no effect.
module cmd_strobe_tx
    import at24_cmd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int HIGH_CYC  = 50,
    parameter int LOW_CYC   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_kind,
    input  logic [2:0] cmd_code,
    output logic [2:0] o_c,
    output logic       o_clk,
    output logic       busy,
    output logic       done
);

    localparam int TW = $clog2(max3(SETUP_CYC, HIGH_CYC, LOW_CYC) + 1);
    localparam logic [TW-1:0] LD_SETUP = TW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [TW-1:0] LD_HIGH  = TW'(HIGH_CYC - 1);
    localparam logic [TW-1:0] LD_LOW   = TW'(LOW_CYC - 1);

    tx_state_t  state_q, state_d;
    cmd_kind_t  kind_q, kind_d;
    logic [2:0] code_q, code_d;
    logic [2:0] step_q, step_d;
    logic [2:0] oc_q, oc_d;
    logic       tmr_load;
    logic [TW-1:0] tmr_val;
    logic       tmr_zero;

    cmd_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State, latched command, frame index and code register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_SINGLE;
            code_q  <= 3'd0;
            step_q  <= 3'd0;
            oc_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            code_q  <= code_d;
            step_q  <= step_d;
            oc_q    <= oc_d;
        end
    end

    // Next-state logic. o_c is only reloaded on acceptance and at the end of
    // a LOW phase, both while the strobe is low. With SETUP_CYC=0 the next
    // frame's code necessarily appears together with the rising strobe.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        code_d   = code_q;
        step_d   = step_q;
        oc_d     = oc_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    kind_d   = cmd_kind_t'(cmd_kind);
                    code_d   = cmd_code;
                    step_d   = 3'd0;
                    oc_d     = frame_code(cmd_kind_t'(cmd_kind), cmd_code, 3'd0);
                    tmr_load = 1'b1;
                    if (SETUP_CYC > 0) begin
                        state_d = ST_SETUP;
                        tmr_val = LD_SETUP;
                    end else begin
                        state_d = ST_HIGH;
                        tmr_val = LD_HIGH;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HIGH;
                end
            end
            ST_HIGH: begin
                if (tmr_zero) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_LOW;
                end
            end
            ST_LOW: begin
                if (tmr_zero) begin
                    if (step_q == frame_last(kind_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d   = step_q + 3'd1;
                        oc_d     = frame_code(kind_q, code_q, step_q + 3'd1);
                        tmr_load = 1'b1;
                        if (SETUP_CYC > 0) begin
                            state_d = ST_SETUP;
                            tmr_val = LD_SETUP;
                        end else begin
                            state_d = ST_HIGH;
                            tmr_val = LD_HIGH;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign o_clk     = (state_q == ST_HIGH);
    assign busy      = (state_q == ST_SETUP) || (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign done      = (state_q == ST_DONE);
    assign o_c       = oc_q;

endmodule

// File: tb/tb_cmd_strobe_tx.sv
// Directed bench for cmd_strobe_tx with default timing (2/50/50).
// Cycle k is the interval after the k-th rising edge; outputs are sampled on
// the falling edge inside it. A command accepted at the end of cycle N shows
// o_c in N+1, raises o_clk in N+3, drops it in N+53 and pulses done in N+103.
module tb_cmd_strobe_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_kind;
    logic [2:0] cmd_code;
    logic [2:0] o_c;
    logic       o_clk;
    logic       busy;
    logic       done;

    cmd_strobe_tx dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_code  (cmd_code),
        .o_c       (o_c),
        .o_clk     (o_clk),
        .busy      (busy),
        .done      (done)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // scoreboard state
    int vectors = 0;
    int miscompares = 0;
    int rise_q[$];
    int fall_q[$];
    int done_q[$];
    int acc_q[$];
    logic [2:0] exp_q[$];
    logic [2:0] code_q[$];
    int hi_change;
    int ready_busy;
    logic prev_clk;
    logic [2:0] prev_c;
    bit timed_out;
    bit bb_mode;
    int bb_left;

    task clear_mon;
        rise_q.delete(); fall_q.delete(); done_q.delete(); acc_q.delete();
        exp_q.delete(); code_q.delete();
        hi_change = 0; ready_busy = 0; timed_out = 0;
        prev_clk = o_clk; prev_c = o_c;
    endtask

    // Observe outputs each cycle until n_done done pulses or n_rise strobes.
    task watch(input int n_done, input int n_rise, input int budget);
        timed_out = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_clk && !prev_clk) begin rise_q.push_back(cyc); code_q.push_back(o_c); end
            if (!o_clk && prev_clk) fall_q.push_back(cyc);
            if (o_c !== prev_c && (o_clk || prev_clk)) hi_change++;
            if (cmd_ready && busy) ready_busy++;
            if (done) done_q.push_back(cyc);
            prev_clk = o_clk; prev_c = o_c;
            if (bb_mode && cmd_valid && cmd_ready) begin
                acc_q.push_back(cyc);
                @(posedge clk); #1;
                bb_left--;
                if (bb_left == 0) cmd_valid = 1'b0;
                else cmd_code = (cmd_code == 3'd1) ? 3'd2 : 3'd1;
            end
            if (done_q.size() >= n_done) return;
            if (n_rise > 0 && rise_q.size() >= n_rise) return;
        end
        timed_out = 1'b1;
    endtask

    // Driver: present one command, return acceptance cycle and next-cycle o_c.
    task send(input logic [1:0] k, input logic [2:0] c, output int acc, output logic [2:0] oc_next);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_kind = k; cmd_code = c;
        @(negedge clk);
        acc = cyc;
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready); end
        @(posedge clk); #1;
        oc_next = o_c;
        cmd_valid = 1'b0; cmd_kind = 2'd3; cmd_code = 3'd6;
    endtask

    task test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'd0; cmd_code = 3'd0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_clk, o_c, busy, done} !== 6'b0) begin miscompares++; $display("FAIL reset_outputs: o_clk/o_c/busy/done=%b required 000000", {o_clk, o_c, busy, done}); end
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready); end
    endtask

    task test_single;
        int acc; logic [2:0] oc1;
        clear_mon();
        send(2'd0, 3'd1, acc, oc1);
        watch(1, 0, 400);
        vectors++;
        if (oc1 !== 3'd1) begin miscompares++; $display("FAIL single_oc: o_c=%0d required 1", oc1); end
        vectors++;
        if (timed_out) begin miscompares++; $display("FAIL single_timeout: done not seen within 400 cycles"); end
        vectors++;
        if (rise_q.size() !== 1) begin miscompares++; $display("FAIL single_strobes: got %0d required 1", rise_q.size()); end
        vectors++;
        if ((rise_q.size() > 0 ? rise_q[0] - acc : -1) !== 3) begin miscompares++; $display("FAIL single_rise: offset %0d required 3", rise_q.size() > 0 ? rise_q[0] - acc : -1); end
        vectors++;
        if ((fall_q.size() > 0 ? fall_q[0] - acc : -1) !== 53) begin miscompares++; $display("FAIL single_fall: offset %0d required 53", fall_q.size() > 0 ? fall_q[0] - acc : -1); end
        vectors++;
        if ((done_q.size() > 0 ? done_q[0] - acc : -1) !== 103) begin miscompares++; $display("FAIL single_done: offset %0d required 103", done_q.size() > 0 ? done_q[0] - acc : -1); end
        vectors++;
        if (hi_change !== 0) begin miscompares++; $display("FAIL single_oc_stable: %0d changes at/while strobe high, required 0", hi_change); end
        @(negedge clk);
        vectors++;
        if ({cmd_ready, busy, done} !== 3'b100) begin miscompares++; $display("FAIL single_after_done: ready/busy/done=%b required 100", {cmd_ready, busy, done}); end
    endtask

    task test_start_macro;
        int acc; logic [2:0] oc1;
        clear_mon();
        send(2'd1, 3'd6, acc, oc1);
        watch(1, 0, 400);
        vectors++;
        if (timed_out || rise_q.size() !== 2) begin miscompares++; $display("FAIL start_strobes: got %0d timeout=%0d required 2", rise_q.size(), timed_out); end
        vectors++;
        if ((code_q.size() == 2 ? {code_q[0], code_q[1]} : 6'h3f) !== {3'd5, 3'd0}) begin miscompares++; $display("FAIL start_codes: got %p required 5,0", code_q); end
        vectors++;
        if ((rise_q.size() == 2 ? rise_q[1] - rise_q[0] : -1) !== 102) begin miscompares++; $display("FAIL start_period: %0d required 102", rise_q.size() == 2 ? rise_q[1] - rise_q[0] : -1); end
        vectors++;
        if (hi_change !== 0) begin miscompares++; $display("FAIL start_oc_stable: %0d changes required 0", hi_change); end
        vectors++;
        if (done_q.size() !== 1) begin miscompares++; $display("FAIL start_done: %0d pulses required 1", done_q.size()); end
    endtask

    task test_discharge;
        int acc; logic [2:0] oc1;
        clear_mon();
        exp_q = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd3};
        send(2'd2, 3'd3, acc, oc1);
        watch(1, 0, 700);
        vectors++;
        if (timed_out || rise_q.size() !== 5) begin miscompares++; $display("FAIL dis_strobes: got %0d timeout=%0d required 5", rise_q.size(), timed_out); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ((i < code_q.size() ? code_q[i] : 3'bx) !== exp_q[i]) begin miscompares++; $display("FAIL dis_code[%0d]: got %0d required %0d", i, i < code_q.size() ? code_q[i] : 3'bx, exp_q[i]); end
        end
        vectors++;
        if (ready_busy !== 0) begin miscompares++; $display("FAIL dis_ready: ready high in %0d busy cycles, required 0", ready_busy); end
        vectors++;
        if (done_q.size() !== 1) begin miscompares++; $display("FAIL dis_done: %0d pulses required 1", done_q.size()); end
        vectors++;
        if (hi_change !== 0) begin miscompares++; $display("FAIL dis_oc_stable: %0d changes required 0", hi_change); end
    endtask

    task test_back_to_back;
        clear_mon();
        for (int i = 0; i < 10; i++) exp_q.push_back((i % 2 == 0) ? 3'd1 : 3'd2);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_kind = 2'd0; cmd_code = 3'd1;
        bb_mode = 1'b1; bb_left = 10;
        watch(10, 0, 1400);
        bb_mode = 1'b0; cmd_valid = 1'b0;
        vectors++;
        if (timed_out || acc_q.size() !== 10) begin miscompares++; $display("FAIL bb_accepts: got %0d timeout=%0d required 10", acc_q.size(), timed_out); end
        vectors++;
        if (rise_q.size() !== 10) begin miscompares++; $display("FAIL bb_strobes: got %0d required 10", rise_q.size()); end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ((i < code_q.size() ? code_q[i] : 3'bx) !== exp_q[i]) begin miscompares++; $display("FAIL bb_code[%0d]: got %0d required %0d", i, i < code_q.size() ? code_q[i] : 3'bx, exp_q[i]); end
        end
        // rise-to-rise: HIGH 50 + LOW 50 + DONE 1 + accept 1 + SETUP 2
        for (int i = 1; i < rise_q.size(); i++) begin
            vectors++;
            if (rise_q[i] - rise_q[i-1] !== 104) begin miscompares++; $display("FAIL bb_gap[%0d]: %0d required 104", i, rise_q[i] - rise_q[i-1]); end
        end
        vectors++;
        if (ready_busy !== 0) begin miscompares++; $display("FAIL bb_ready: ready high in %0d busy cycles, required 0", ready_busy); end
    endtask

    task test_reset_abort;
        int acc; logic [2:0] oc1;
        clear_mon();
        send(2'd2, 3'd3, acc, oc1);
        watch(99, 3, 600);
        repeat (5) @(negedge clk);
        vectors++;
        if (timed_out || o_clk !== 1'b1 || o_c !== 3'd7) begin miscompares++; $display("FAIL abort_in_high: o_clk=%b o_c=%0d timeout=%0d required 1,7", o_clk, o_c, timed_out); end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({o_clk, o_c, busy, done} !== 6'b0) begin miscompares++; $display("FAIL abort_outputs: o_clk/o_c/busy/done=%b required 000000", {o_clk, o_c, busy, done}); end
        clear_mon();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        watch(1, 0, 120);
        vectors++;
        if (done_q.size() !== 0 || rise_q.size() !== 0) begin miscompares++; $display("FAIL abort_quiet: done=%0d strobes=%0d required 0,0", done_q.size(), rise_q.size()); end
        test_single();
    endtask

    initial begin
        bb_mode = 1'b0; bb_left = 0;
        test_reset();
        test_single();
        test_start_macro();
        test_discharge();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
